// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Priority modes and a clog2 variant that never yields a zero-width code.
package prio_enc_pkg;

    localparam int PE_FIXED = 0;
    localparam int PE_RR    = 1;

    // A 2-line encoder still needs one code bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_pipe_scan.sv
// Combinational request scan for prio_enc_pipe.
// Fixed mode returns the highest set index; round-robin returns the first set index at or above start.
module prio_scan
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [W-1:0]   fix_idx_s;
    logic [W-1:0]   rot_idx_s;
    logic [W:0]     sum_s;
    logic [W:0]     unrot_s;

    // Rotating right by start moves the pointer slot to bit 0, so a lowest-set search wraps naturally.
    always_comb begin
        dbl_s     = {req, req} >> start;
        rot_s     = dbl_s[N-1:0];
        fix_idx_s = {W{1'b0}};
        rot_idx_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            fix_idx_s = req[i] ? W'(i) : fix_idx_s;
        end
        for (int i = N - 1; i >= 0; i--) begin
            rot_idx_s = rot_s[i] ? W'(i) : rot_idx_s;
        end
        sum_s = {1'b0, rot_idx_s} + {1'b0, start};
        if (sum_s >= (W+1)'(N)) begin
            unrot_s = sum_s - (W+1)'(N);
        end else begin
            unrot_s = sum_s;
        end
        found = |req;
        idx   = mode ? unrot_s[W-1:0] : fix_idx_s;
    end

endmodule

// File: rtl/prio_enc_pipe.sv
// Registered N-line priority encoder with valid/ready handshake.
// Single output stage; round-robin pointer advances past each granted index.
module prio_enc_pipe
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = PE_FIXED,
    parameter int W    = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] code,
    output logic [N-1:0] grant,
    output logic         none
);

    localparam logic MODE_RR = (MODE == PE_RR) ? 1'b1 : 1'b0;

    logic         found_s;
    logic [W-1:0] idx_s;
    logic         accept_s;
    logic [N-1:0] grant_s;
    logic [W-1:0] ptr_next_s;

    logic         out_valid_r;
    logic [W-1:0] code_r;
    logic [N-1:0] grant_r;
    logic         none_r;
    logic [W-1:0] ptr_r;

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    prio_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .req   (req),
        .start (ptr_r),
        .mode  (MODE_RR),
        .found (found_s),
        .idx   (idx_s)
    );

    // One-hot grant for the winner and the wrapped successor index for the pointer.
    always_comb begin
        grant_s    = found_s ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};
        ptr_next_s = (idx_s == W'(N - 1)) ? {W{1'b0}} : idx_s + W'(1);
    end

    // Output stage and round-robin pointer; an all-zero request leaves the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            code_r      <= {W{1'b0}};
            grant_r     <= {N{1'b0}};
            none_r      <= 1'b1;
            ptr_r       <= {W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            code_r      <= found_s ? idx_s : {W{1'b0}};
            grant_r     <= grant_s;
            none_r      <= !found_s;
            if (found_s && MODE_RR) begin
                ptr_r <= ptr_next_s;
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign code      = code_r;
    assign grant     = grant_r;
    assign none      = none_r;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Bench for prio_enc_pipe: six instances (N=8/2/64, fixed and round-robin) share one handshake.
// A per-instance model feeds a scoreboard queue; table rows and directed sequences add fixed expectations.
module tb_prio_enc_pipe;
    import prio_enc_pkg::*;

    typedef struct packed {
        logic [5:0]  code;
        logic [63:0] grant;
        logic        none;
    } res_t;

    typedef struct {
        logic [7:0] req;
        logic [2:0] fix_code;
        logic       fix_none;
        logic [2:0] rr_code;
        logic       rr_none;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] req_bus = 64'd0;

    logic [5:0]  in_ready_v;
    logic [5:0]  out_valid_v;
    logic [5:0]  none_v;
    logic [5:0]  code_o [6];
    logic [63:0] grant_o [6];

    int inst_n  [6] = '{8, 8, 2, 2, 64, 64};
    bit inst_rr [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mvalid;
    int   ptr_m [6];
    res_t cur [6];
    res_t sb_q [6][$];
    vec_t tbl [9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : gi
        localparam int NN = (g < 2) ? 8 : ((g < 4) ? 2 : 64);
        localparam int MM = (g % 2 == 1) ? PE_RR : PE_FIXED;
        logic [NN-1:0]              gr;
        logic [clog2_min1(NN)-1:0] cd;
        prio_enc_pipe #(.N(NN), .MODE(MM)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req_bus[NN-1:0]),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .code      (cd),
            .grant     (gr),
            .none      (none_v[g])
        );
        assign code_o[g]  = 6'(cd);
        assign grant_o[g] = 64'(gr);
    end

    task automatic check(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, g, act, exp);
        end
    endtask

    function automatic res_t model(input int n, input bit rr, input logic [63:0] r, input int p);
        res_t o;
        o.code  = 6'd0;
        o.grant = 64'd0;
        o.none  = 1'b1;
        if (rr) begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (p + k) % n;
                if (r[i]) begin
                    o.code = 6'(i); o.grant = 64'd1 << i; o.none = 1'b0;
                    break;
                end
            end
        end else begin
            for (int i = n - 1; i >= 0; i--) begin
                if (r[i]) begin
                    o.code = 6'(i); o.grant = 64'd1 << i; o.none = 1'b0;
                    break;
                end
            end
        end
        return o;
    endfunction

    function automatic int gidx(input logic [63:0] gr);
        for (int i = 0; i < 64; i++) begin
            if (gr[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mvalid = 1'b0;
        for (int g = 0; g < 6; g++) begin
            ptr_m[g] = 0;
            sb_q[g].delete();
            cur[g].code  = 6'd0;
            cur[g].grant = 64'd0;
            cur[g].none  = 1'b1;
        end
    endtask

    task automatic check_outputs();
        for (int g = 0; g < 6; g++) begin
            check("out_valid", g, 64'(out_valid_v[g]), 64'(mvalid));
            check("code", g, 64'(code_o[g]), 64'(cur[g].code));
            check("grant", g, grant_o[g], cur[g].grant);
            check("none", g, 64'(none_v[g]), 64'(cur[g].none));
            check("onehot0", g, 64'($onehot0(grant_o[g])), 64'd1);
            check("none_vs_grant", g, 64'(none_v[g]), 64'(grant_o[g] == 64'd0));
            if (grant_o[g] != 64'd0) begin
                check("code_idx", g, 64'(code_o[g]), 64'(gidx(grant_o[g])));
            end
        end
    endtask

    // One clock: drive at negedge, check in_ready, predict, then compare outputs at the next negedge.
    task automatic cycle(input logic v, input logic [63:0] r, input logic ordy);
        logic acc;
        res_t res;
        in_valid  = v;
        req_bus   = r;
        out_ready = ordy;
        #1;
        acc = v && (!mvalid || ordy);
        for (int g = 0; g < 6; g++) begin
            check("in_ready", g, 64'(in_ready_v[g]), 64'(!mvalid || ordy));
            if (acc) begin
                res = model(inst_n[g], inst_rr[g], r, ptr_m[g]);
                sb_q[g].push_back(res);
                if (inst_rr[g] && !res.none) ptr_m[g] = (int'(res.code) + 1) % inst_n[g];
            end
        end
        @(posedge clk);
        @(negedge clk);
        mvalid = acc ? 1'b1 : (ordy ? 1'b0 : mvalid);
        if (acc) begin
            for (int g = 0; g < 6; g++) cur[g] = sb_q[g].pop_front();
        end
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        req_bus  = 64'hFFFF_FFFF_FFFF_FFFF;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 6; g++) begin
            check("rst_out_valid", g, 64'(out_valid_v[g]), 64'd0);
            check("rst_none", g, 64'(none_v[g]), 64'd1);
            check("rst_grant", g, grant_o[g], 64'd0);
            check("rst_code", g, 64'(code_o[g]), 64'd0);
            check("rst_in_ready", g, 64'(in_ready_v[g]), 64'd1);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] r;
        tbl[0] = '{8'h00, 3'd0, 1'b1, 3'd0, 1'b1};
        tbl[1] = '{8'hFF, 3'd7, 1'b0, 3'd0, 1'b0};
        tbl[2] = '{8'h81, 3'd7, 1'b0, 3'd7, 1'b0};
        tbl[3] = '{8'h06, 3'd2, 1'b0, 3'd1, 1'b0};
        tbl[4] = '{8'h24, 3'd5, 1'b0, 3'd2, 1'b0};
        tbl[5] = '{8'h24, 3'd5, 1'b0, 3'd5, 1'b0};
        tbl[6] = '{8'h24, 3'd5, 1'b0, 3'd2, 1'b0};
        tbl[7] = '{8'h80, 3'd7, 1'b0, 3'd7, 1'b0};
        tbl[8] = '{8'h01, 3'd0, 1'b0, 3'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 64'(tbl[i].req), 1'b1);
            check("tbl_fix_code", i, 64'(code_o[0]), 64'(tbl[i].fix_code));
            check("tbl_fix_none", i, 64'(none_v[0]), 64'(tbl[i].fix_none));
            check("tbl_rr_code", i, 64'(code_o[1]), 64'(tbl[i].rr_code));
            check("tbl_rr_none", i, 64'(none_v[1]), 64'(tbl[i].rr_none));
        end

        // Round-robin fairness with every line requesting, then a two-line pattern from ptr=2.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 64'hFF, 1'b1);
            check("rr_fair", i, 64'(code_o[1]), 64'(i % 8));
        end
        cycle(1'b1, 64'h24, 1'b1);
        check("rr_pair0", 1, 64'(code_o[1]), 64'd2);
        cycle(1'b1, 64'h24, 1'b1);
        check("rr_pair1", 1, 64'(code_o[1]), 64'd5);
        cycle(1'b1, 64'h24, 1'b1);
        check("rr_pair2", 1, 64'(code_o[1]), 64'd2);

        // Backpressure: result held four cycles, new request refused, pointer frozen.
        cycle(1'b1, 64'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 64'h0F, 1'b0);
            check("stall_hold_fix", i, 64'(code_o[0]), 64'd4);
            check("stall_hold_rr", i, 64'(code_o[1]), 64'd4);
        end
        cycle(1'b1, 64'h0F, 1'b1);
        check("drain_fix", 0, 64'(code_o[0]), 64'd3);
        check("drain_rr", 1, 64'(code_o[1]), 64'd0);

        // Asynchronous reset between edges while a result is stalled.
        cycle(1'b1, 64'hFF, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 6; g++) begin
            check("async_out_valid", g, 64'(out_valid_v[g]), 64'd0);
            check("async_none", g, 64'(none_v[g]), 64'd1);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 64'hFF, 1'b1);
        check("post_rst_rr", 1, 64'(code_o[1]), 64'd0);

        // Random traffic across all widths and modes.
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       r = 64'd0;
                1:       r = r & {$urandom, $urandom} & {$urandom, $urandom};
                default: r = r;
            endcase
            cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
